// File: rtl/uart_hex_printer.sv
// Prints each queued 32-bit word as DIGITS uppercase hex characters to a byte-wide UART stream.
// Define UART_HEX_PRINTER_CRLF_EN to terminate every word with CR LF.
module uart_hex_printer #(
    parameter int DEPTH  = 4,
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

`ifdef UART_HEX_PRINTER_CRLF_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DIGIT = 2'd1, CR = 2'd2, LF = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DIGIT = 2'd1} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        accept;
    logic        last_char;
    logic        rst_done;
    logic [31:0] word_q;
    logic [2:0]  idx;
    logic [3:0]  nibble;

    // Handshakes: a transfer happens on a rising edge where valid && ready, on both sides.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = rst_done && !full;
    assign push     = in_valid && in_ready;
    assign accept   = out_valid && out_ready;
    assign busy     = (state != IDLE) || !empty;

`ifdef UART_HEX_PRINTER_CRLF_EN
    assign last_char = accept && (state == LF);
`else
    assign last_char = accept && (state == DIGIT) && (idx == 3'd0);
`endif

    // Popping straight out of the last character avoids a bubble between words.
    assign pop = !empty && ((state == IDLE) || last_char);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rst_done <= 1'b0;
            word_q   <= '0;
            idx      <= '0;
        end else begin
            rst_done <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                word_q <= mem[rd_ptr[AW-1:0]];
                idx    <= 3'(DIGITS - 1);
            end else if ((state == DIGIT) && accept && (idx != 3'd0)) begin
                idx <= idx - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = DIGIT;
            end
            DIGIT: begin
                if (accept && (idx == 3'd0)) begin
`ifdef UART_HEX_PRINTER_CRLF_EN
                    state_nxt = CR;
`else
                    state_nxt = empty ? IDLE : DIGIT;
`endif
                end
            end
`ifdef UART_HEX_PRINTER_CRLF_EN
            CR: begin
                if (accept) state_nxt = LF;
            end
            LF: begin
                if (accept) state_nxt = empty ? IDLE : DIGIT;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign nibble = word_q[{idx, 2'b00} +: 4];

    always_comb begin
        out_valid = (state != IDLE);
        out_data  = 8'h00;
        case (state)
            DIGIT: out_data = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
`ifdef UART_HEX_PRINTER_CRLF_EN
            CR:    out_data = 8'h0D;
            LF:    out_data = 8'h0A;
`endif
            default: out_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Directed bench for uart_hex_printer: a DIGITS=8 instance and a DIGITS=2 instance.
module tb_uart_hex_printer;

`ifdef UART_HEX_PRINTER_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam int CPW  = 8 + (CRLF ? 2 : 0);
    localparam int CPW2 = 2 + (CRLF ? 2 : 0);

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [31:0] in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2;

    int          n_checks = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;
    int          acc2_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp2_q[$];
    logic        hold_v = 1'b0;
    logic [7:0]  hold_d = 8'h00;

    always #5 clk = ~clk;

    uart_hex_printer #(.DEPTH(4), .DIGITS(8)) dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    uart_hex_printer #(.DEPTH(4), .DIGITS(2)) dut2 (
        .clk(clk), .resetn(resetn), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + 8'(n);
        return 8'd65 + 8'(n) - 8'd10;
    endfunction

    task automatic expect_word(input logic [31:0] w, input int digits, input bit second);
        logic [7:0] c;
        for (int i = digits - 1; i >= 0; i--) begin
            c = hex_char(w[i*4 +: 4]);
            if (second) exp2_q.push_back(c); else exp_q.push_back(c);
        end
        if (CRLF) begin
            if (second) begin exp2_q.push_back(8'h0D); exp2_q.push_back(8'h0A); end
            else begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); end
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every accepted character must match the head of the expected queue.
    always @(negedge clk) begin
        if (!resetn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hold_d));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_char", 32'(exp_q.size()), 32'd1);
                else check("char", 32'(out_data), 32'(exp_q.pop_front()));
                acc_cnt++;
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    always @(negedge clk) begin
        if (resetn && out_valid2 && out_ready2) begin
            if (exp2_q.size() == 0) check("extra_char2", 32'(exp2_q.size()), 32'd1);
            else check("char2", 32'(out_data2), 32'(exp2_q.pop_front()));
            acc2_cnt++;
        end
    end

    initial begin
        logic [31:0] wl [6];
        int base;
        int n_acc;
        int vcnt;
        int last;
        bit seen;

        resetn = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_in_ready2", 32'(in_ready2), 32'd0);
        check("rst_out_valid2", 32'(out_valid2), 32'd0);
        resetn = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready), 32'd1);
        check("in_ready2_after_edge", 32'(in_ready2), 32'd1);

        // Single word, free-running receiver, with latency
        base = acc_cnt;
        out_ready = 1'b1;
        expect_word(32'h1234ABCD, 8, 1'b0);
        in_data = 32'h1234ABCD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("latency_edge_n", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_edge_n1", 32'(out_valid), 32'd1);
        wait_drain(100);
        check("word1_busy", 32'(busy), 32'd0);
        check("word1_count", 32'(acc_cnt - base), 32'(CPW));

        // Back-pressure fills FIFO: 1 in FSM plus DEPTH queued
        base = acc_cnt;
        out_ready = 1'b0;
        wl = '{32'h01234567, 32'h89ABCDEF, 32'h00000000, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'hC0FFEE11};
        for (int i = 0; i < 6; i++) expect_word(wl[i], 8, 1'b0);
        in_valid = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = wl[i];
            if (!in_ready) break;
            @(posedge clk);
            #1;
            n_acc++;
        end
        if (n_acc == 6) in_valid = 1'b0;
        check("accepted_before_full", 32'(n_acc), 32'd5);
        for (int i = 0; i < 4; i++) begin
            check("full_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) seen = 1'b1;
        end
        check("room_seen", 32'(seen), 32'd1);
        check("chars_before_room", 32'(acc_cnt - base), 32'(CPW));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain(300);
        check("six_words_count", 32'(acc_cnt - base), 32'(6 * CPW));

        // Random stalls
        base = acc_cnt;
        expect_word(32'hFEDCBA98, 8, 1'b0);
        in_data = 32'hFEDCBA98; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 300 && (busy || exp_q.size() != 0); i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        check("random_stall_count", 32'(acc_cnt - base), 32'(CPW));
        check("random_stall_idle", 32'(busy), 32'd0);

        // Receiver drops ready for one cycle after every accept
        base = acc_cnt;
        out_ready = 1'b1;
        expect_word(32'h0F1E2D3C, 8, 1'b0);
        in_data = 32'h0F1E2D3C; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = acc_cnt;
        for (int i = 0; i < 100 && (busy || exp_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
            out_ready = (acc_cnt == last);
            last = acc_cnt;
        end
        check("drop_ready_count", 32'(acc_cnt - base), 32'(CPW));

        // Reset mid-word with two words queued
        out_ready = 1'b1;
        base = acc_cnt;
        for (int i = 7; i >= 5; i--) exp_q.push_back(hex_char(wl[0][i*4 +: 4]));
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = wl[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && (acc_cnt - base) < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("chars_before_reset", 32'(acc_cnt - base), 32'd3);
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_post", 32'(in_ready), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("no_resume_chars", 32'(acc_cnt - base), 32'd3);
        check("no_resume_busy", 32'(busy), 32'd0);

        // Back-to-back words with no gap cycle
        base = acc_cnt;
        expect_word(32'h0000000F, 8, 1'b0);
        expect_word(32'h00000010, 8, 1'b0);
        in_valid = 1'b1; in_data = 32'h0000000F;
        @(posedge clk);
        #1;
        in_data = 32'h00000010;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 2 * CPW; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check("no_gap_valid_cycles", 32'(vcnt), 32'(2 * CPW));
        wait_drain(100);
        check("two_words_count", 32'(acc_cnt - base), 32'(2 * CPW));

        // Two-digit instance
        expect_word(32'hFFFFFF5A, 2, 1'b1);
        in_data2 = 32'hFFFFFF5A; in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        for (int i = 0; i < 50 && (busy2 || exp2_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("digits2_count", 32'(acc2_cnt), 32'(CPW2));
        check("digits2_busy", 32'(busy2), 32'd0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp2_q_empty", 32'(exp2_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_hex_printer.md
UART_HEX_PRINTER -- requirements
Module: uart_hex_printer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: word FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter DIGITS, default 8: hex digits printed per word, 1..8, taken from in_data[4*DIGITS-1:0].
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, 32: word to print.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: FIFO can accept a word.
REQ-008 SHALL have port out_data, output, 8: ASCII character for the downstream UART transmitter.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: downstream transmitter is idle and takes out_data.
REQ-011 SHALL have port busy, output, 1: a word is queued or being printed.

Function
REQ-012 SHALL push in_data into the FIFO on a rising edge where in_valid && in_ready.
REQ-013 SHALL drive in_ready = !full; a word SHALL NOT be accepted when full, even if a pop happens on the same edge.
REQ-014 SHALL transfer a character on a rising edge where out_valid && out_ready.
REQ-015 SHALL use FSM states IDLE, DIGIT, CR, LF, with out_valid = (state != IDLE).
REQ-016 IDLE: when the FIFO is non-empty, SHALL pop one word into a shift register, set digit index = DIGITS-1 and go to DIGIT.
REQ-017 DIGIT: out_data SHALL be the uppercase ASCII hex of nibble[index]: 0x30..0x39 for 0..9, 0x41..0x46 for A..F.
REQ-018 DIGIT accept with index>0: SHALL decrement the index; with index==0: SHALL go to CR.
REQ-019 CR SHALL output 0x0D and go to LF on accept; LF SHALL output 0x0A.
REQ-020 On accept of the last character of a word: SHALL pop the next word directly into DIGIT if the FIFO is non-empty, otherwise go to IDLE; no bubble cycle.
REQ-021 Latency: a word accepted into an empty FIFO at edge N SHALL give out_valid high after edge N+1.
REQ-022 out_data SHALL stay stable while out_valid && !out_ready.
REQ-023 The block SHALL NOT drop or duplicate characters under any out_ready pattern.
REQ-024 out_valid SHALL deassert, or out_data SHALL advance, in the cycle after each accept.
REQ-025 The downstream transmitter lowers its ready one cycle after accepting; the block SHALL tolerate this.
REQ-026 busy SHALL be (state != IDLE) || FIFO non-empty.
REQ-027 FIFO pointers SHALL be log2(DEPTH) bits plus one wrap bit; full and empty SHALL be decoded from pointer equality and the wrap bit.

Reset
REQ-028 resetn low SHALL asynchronously set state IDLE, empty the FIFO and reset the digit index.
REQ-029 During reset, out_valid, busy and out_data SHALL be 0, and in_ready SHALL be 0.
REQ-030 in_ready SHALL be 1 from the first clock edge after resetn is released.
REQ-031 Reset mid-word SHALL discard the partial word and all queued words; printing SHALL NOT resume after release.

Configuration
REQ-032 Macro UART_HEX_PRINTER_CRLF_EN defined: the CR and LF states SHALL be present and each word SHALL end with 0x0D 0x0A.
REQ-033 Macro undefined: the CR and LF states SHALL be absent, and DIGIT index==0 accept SHALL act as the last character (REQ-020).

Verification
REQ-034 CRLF_EN, out_ready=1, push 0x1234ABCD -> out 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A, then busy=0.
REQ-035 out_ready=0, push 6 words back-to-back -> first 5 accepted (1 in FSM plus DEPTH=4), in_ready=0 on the 6th until word 1 completes.
REQ-036 Push 0xFEDCBA98, toggle out_ready randomly -> out_data stable while stalled, exactly 10 characters, in order.
REQ-037 Pull resetn low after the 3rd character, with 2 words queued -> out_valid=0 and busy=0 immediately, no characters after release, in_ready=1 after the first edge.
REQ-038 Macro undefined, push 0x0000000F then 0x00000010 back-to-back -> "0000000F00000010" with no gap cycle between words.
REQ-039 DIGITS=2, CRLF_EN, push 0xFFFFFF5A -> 0x35 0x41 0x0D 0x0A.
